// File: rtl/bit_serializer_pkg.sv
// Shared types for the bit serializer: FSM state type and its debug encodings.
package ser_pkg;

   localparam logic [1:0] SER_IDLE_ENC   = 2'd0;
   localparam logic [1:0] SER_SHIFT_ENC  = 2'd1;
   localparam logic [1:0] SER_PARITY_ENC = 2'd2;
   localparam logic [1:0] SER_GAP_ENC    = 2'd3;

   typedef enum logic [1:0] {
      SER_IDLE   = SER_IDLE_ENC,
      SER_SHIFT  = SER_SHIFT_ENC,
      SER_PARITY = SER_PARITY_ENC,
      SER_GAP    = SER_GAP_ENC
   } ser_state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feed stage with a one-deep holding buffer, inter-word gap and stall.
// Optional even-parity bit after each word when SER_PARITY_EN is defined.
module bit_serializer
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned GAP       = 0,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             stall,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             word_done,
   output logic             busy,
   output logic [1:0]       state_out
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
   localparam ser_state_t  AFTER_WORD = (GAP > 0) ? SER_GAP : SER_IDLE;

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             buf_full_q, buf_full_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic             bit_out_q, bit_out_d;
   logic             bit_valid_q, bit_valid_d;
   logic             word_done_q, word_done_d;
`ifdef SER_PARITY_EN
   logic             par_q, par_d;
`endif

   assign s_ready   = !buf_full_q && !reset;
   assign bit_out   = bit_out_q;
   assign bit_valid = bit_valid_q;
   assign word_done = word_done_q;
   assign busy      = (state_q != SER_IDLE) || buf_full_q;
   assign state_out = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SER_IDLE;
         buf_q       <= '0;
         buf_full_q  <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         word_done_q <= 1'b0;
`ifdef SER_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         buf_full_q  <= buf_full_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         bit_out_q   <= bit_out_d;
         bit_valid_q <= bit_valid_d;
         word_done_q <= word_done_d;
`ifdef SER_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      buf_full_d  = buf_full_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      bit_out_d   = bit_out_q;
      bit_valid_d = 1'b0;
      word_done_d = 1'b0;
`ifdef SER_PARITY_EN
      par_d       = par_q;
`endif

      // Accept never coincides with a load: s_ready is low whenever the buffer holds a word.
      if (s_valid && s_ready) begin
         buf_d      = s_data;
         buf_full_d = 1'b1;
      end

      if (!stall) begin
         case (state_q)
            SER_IDLE: begin
               if (buf_full_q) begin
                  buf_full_d  = 1'b0;
                  bit_valid_d = 1'b1;
                  bit_out_d   = MSB_FIRST ? buf_q[WIDTH-1] : buf_q[0];
                  shift_d     = MSB_FIRST ? {buf_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, buf_q[WIDTH-1:1]};
                  cnt_d       = CW'(1);
                  state_d     = SER_SHIFT;
`ifdef SER_PARITY_EN
                  par_d       = ^buf_q;
`endif
               end
            end
            SER_SHIFT: begin
               bit_valid_d = 1'b1;
               bit_out_d   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
               shift_d     = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, shift_q[WIDTH-1:1]};
               cnt_d       = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SER_PARITY_EN
                  state_d = SER_PARITY;
`else
                  word_done_d = 1'b1;
                  state_d     = AFTER_WORD;
                  gap_d       = GW'(GAP);
`endif
               end
            end
`ifdef SER_PARITY_EN
            SER_PARITY: begin
               bit_valid_d = 1'b1;
               bit_out_d   = par_q;
               word_done_d = 1'b1;
               state_d     = AFTER_WORD;
               gap_d       = GW'(GAP);
            end
`endif
            SER_GAP: begin
               gap_d = gap_q - GW'(1);
               if (gap_q <= GW'(1)) begin
                  state_d = SER_IDLE;
               end
            end
            default: state_d = SER_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized bench for bit_serializer: two instances (MSB-first/no gap, LSB-first/GAP=3)
// checked every cycle against a word/position reference model.
module tb_bit_serializer;
   import ser_pkg::*;

   localparam int W     = 8;
   localparam int GAP_B = 3;
`ifdef SER_PARITY_EN
   localparam int L = W + 1;
`else
   localparam int L = W;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] s_data;
   logic         s_valid;
   logic         stall;
   logic [1:0]   rdy, bo, bv, wd, bz;
   logic [1:0]   st_a, st_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .GAP(0), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[0]),
      .stall(stall), .bit_out(bo[0]), .bit_valid(bv[0]), .word_done(wd[0]),
      .busy(bz[0]), .state_out(st_a)
   );

   bit_serializer #(.WIDTH(W), .GAP(GAP_B), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[1]),
      .stall(stall), .bit_out(bo[1]), .bit_valid(bv[1]), .word_done(wd[1]),
      .busy(bz[1]), .state_out(st_b)
   );

   // Reference model: each DUT is a buffered word plus the position of the next bit to send.
   int unsigned  gap_p [2] = '{0, GAP_B};
   bit           msb_p [2] = '{1'b1, 1'b0};
   bit           m_full [2];
   logic [W-1:0] m_buf [2];
   logic [W-1:0] m_cur [2];
   int           m_pos [2];
   int           m_gap [2];
   logic         m_out [2];
   logic         m_v [2];
   logic         m_d [2];
   bit           m_acc [2];

   logic [W-1:0] sent_q [$];
   logic [W:0]   col;
   int           ncol;
   int           nbits_a;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic nb(input int m, input int k);
      logic [W-1:0] w;
      int idx;
      w = m_cur[m];
      if (k == W) return ^w;
      idx = msb_p[m] ? (W - 1 - k) : k;
      return w[idx];
   endfunction

   function automatic logic [1:0] exp_state(input int m);
      if (m_pos[m] < L) return (m_pos[m] == W) ? 2'd2 : 2'd1;
      if (m_gap[m] > 0) return 2'd3;
      return 2'd0;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_full[m] = 1'b0; m_buf[m] = '0; m_cur[m] = '0;
         m_pos[m] = L; m_gap[m] = 0;
         m_out[m] = 1'b0; m_v[m] = 1'b0; m_d[m] = 1'b0; m_acc[m] = 1'b0;
      end
      sent_q.delete();
      col = '0;
      ncol = 0;
   endtask

   task automatic model_edge(input int m);
      bit acc;
      acc = s_valid && !m_full[m];
      m_v[m] = 1'b0;
      m_d[m] = 1'b0;
      if (!stall) begin
         if (m_pos[m] < L) begin
            m_out[m] = nb(m, m_pos[m]);
            m_v[m] = 1'b1;
            m_pos[m]++;
            if (m_pos[m] == L) begin
               m_d[m] = 1'b1;
               m_gap[m] = gap_p[m];
            end
         end else if (m_gap[m] > 0) begin
            m_gap[m]--;
         end else if (m_full[m]) begin
            m_cur[m] = m_buf[m];
            m_full[m] = 1'b0;
            m_out[m] = nb(m, 0);
            m_v[m] = 1'b1;
            m_pos[m] = 1;
         end
      end
      if (acc) begin
         m_full[m] = 1'b1;
         m_buf[m] = s_data;
         if (m == 0) sent_q.push_back(s_data);
      end
      m_acc[m] = acc;
   endtask

   task automatic check_all();
      logic [W-1:0] w;
      chk("A.bit_valid", bv[0], m_v[0]);
      chk("A.word_done", wd[0], m_d[0]);
      chk("A.bit_out",   bo[0], m_out[0]);
      chk("A.busy",      bz[0], (m_pos[0] < L) || (m_gap[0] > 0) || m_full[0]);
      chk("A.s_ready",   rdy[0], !m_full[0] && !reset);
      chk("A.state",     st_a, exp_state(0));
      chk("B.bit_valid", bv[1], m_v[1]);
      chk("B.word_done", wd[1], m_d[1]);
      chk("B.bit_out",   bo[1], m_out[1]);
      chk("B.busy",      bz[1], (m_pos[1] < L) || (m_gap[1] > 0) || m_full[1]);
      chk("B.s_ready",   rdy[1], !m_full[1] && !reset);
      chk("B.state",     st_b, exp_state(1));
      // Independent scoreboard: reassemble DUT A's serial stream into whole words.
      if (bv[0] === 1'b1) begin
         col = {col[W-1:0], bo[0]};
         ncol++;
      end
      if (wd[0] === 1'b1) begin
         chk("A.word_len", ncol, L);
         if (sent_q.size() == 0) begin
            chk("A.word_q", sent_q.size(), 1);
         end else begin
            w = sent_q.pop_front();
`ifdef SER_PARITY_EN
            chk("A.word", col[W:1], w);
            chk("A.parity", col[0], ^w);
`else
            chk("A.word", col[W-1:0], w);
`endif
         end
         ncol = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!reset) begin
         model_edge(0);
         model_edge(1);
         if (m_v[0]) nbits_a++;
      end
      #1;
      check_all();
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      repeat (cycles) step();
      reset = 1'b0;
      #1;
      check_all();
   endtask

   task automatic send_word(input logic [W-1:0] d);
      bit ok;
      ok = 1'b0;
      s_valid = 1'b1;
      s_data = d;
      for (int i = 0; i < 40 && !ok; i++) begin
         step();
         ok = m_acc[0];
      end
      if (!ok) chk("accept_timeout", ok, 1);
      s_valid = 1'b0;
   endtask

   task automatic wait_bits_a(input int n);
      for (int i = 0; i < 40 && nbits_a < n; i++) step();
      chk("bit_wait", nbits_a, n);
   endtask

   initial begin
      reset = 1'b1; s_valid = 1'b0; s_data = '0; stall = 1'b0;
      model_reset();
      #2;
      do_reset(2);
      step();

      send_word(8'hB5);
      repeat (12) step();

      send_word(8'hA0);
      send_word(8'h0F);
      repeat (40) step();

      nbits_a = 0;
      send_word(8'hB5);
      wait_bits_a(3);
      stall = 1'b1;
      repeat (2) step();
      stall = 1'b0;
      repeat (12) step();

      nbits_a = 0;
      send_word(8'hFF);
      wait_bits_a(4);
      do_reset(2);
      send_word(8'h81);
      repeat (14) step();

      send_word(8'h03);
      repeat (14) step();

      for (int i = 0; i < 3000; i++) begin
         s_valid = ($urandom_range(0, 99) < 60);
         s_data  = W'($urandom);
         stall   = ($urandom_range(0, 99) < 15);
         if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 3));
         else step();
      end
      s_valid = 1'b0;
      stall = 1'b0;
      repeat (30) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
